// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-style datapath: opcodes, immediate
// extension modes, instruction field positions and the decode bundle.
package cpu_pkg;

    // Major opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // How the 16-bit immediate is widened to 32 bits
    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_mode_t;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // Registered decode bundle handed to execute
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        ext_mode_t   ext_mode;
        logic        rtype;
        logic [31:0] pc4;
    } decode_t;

endpackage

// File: rtl/imm_ext.sv
// Widens a 16-bit immediate to 32 bits according to the selected mode.
module imm_ext
    import cpu_pkg::*;
(
    input  logic [15:0] imm_i,
    input  ext_mode_t   mode_i,
    output logic [31:0] ext_o
);

    // Pick sign, zero or upper-half placement; unknown modes fall back to sign
    always_comb begin
        ext_o = {{16{imm_i[15]}}, imm_i};
        case (mode_i)
            EXT_ZERO:  ext_o = {16'h0000, imm_i};
            EXT_UPPER: ext_o = {imm_i, 16'h0000};
            default:   ext_o = {{16{imm_i[15]}}, imm_i};
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Registered instruction-decode stage: one-entry pipeline register with a
// valid/ready handshake on both sides, immediate extension and a saturating
// count of back-pressure cycles.
module id_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_instr,
    input  logic [DATA_W-1:0]      in_pc4,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             out_opcode,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_shamt,
    output logic [5:0]             out_funct,
    output logic [DATA_W-1:0]      out_imm,
    output logic [1:0]             out_ext_mode,
    output logic                   out_rtype,
    output logic [DATA_W-1:0]      out_pc4,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   valid_q, valid_d;
    decode_t                bundle_q, bundle_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic                   load;
    ext_mode_t              mode_sel;
    logic [31:0]            imm_val;
    logic [5:0]             opcode;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign opcode   = in_instr[OPC_HI:OPC_LO];

    // Opcode-to-extension lookup: logical immediates zero-extend, LUI goes high
    always_comb begin
        mode_sel = EXT_SIGN;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: mode_sel = EXT_ZERO;
            OP_LUI:                   mode_sel = EXT_UPPER;
            default:                  mode_sel = EXT_SIGN;
        endcase
    end

    imm_ext u_imm_ext (
        .imm_i  (in_instr[IMM_HI:IMM_LO]),
        .mode_i (mode_sel),
        .ext_o  (imm_val)
    );

    // Next state: flush beats load, load beats drain; data only moves on load
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        stall_d  = stall_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (load) begin
            bundle_d.opcode   = opcode;
            bundle_d.rs       = in_instr[RS_HI:RS_LO];
            bundle_d.rt       = in_instr[RT_HI:RT_LO];
            bundle_d.rd       = in_instr[RD_HI:RD_LO];
            bundle_d.shamt    = in_instr[SHAMT_HI:SHAMT_LO];
            bundle_d.funct    = in_instr[FUNCT_HI:FUNCT_LO];
            bundle_d.imm      = imm_val;
            bundle_d.ext_mode = mode_sel;
            bundle_d.rtype    = (opcode == OP_RTYPE);
            bundle_d.pc4      = in_pc4;
        end

        // Count back-pressure cycles, sticking at all-ones
        if (valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    // State registers; reset discards any held entry immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            stall_q  <= stall_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_opcode   = bundle_q.opcode;
    assign out_rs       = bundle_q.rs;
    assign out_rt       = bundle_q.rt;
    assign out_rd       = bundle_q.rd;
    assign out_shamt    = bundle_q.shamt;
    assign out_funct    = bundle_q.funct;
    assign out_imm      = bundle_q.imm;
    assign out_ext_mode = bundle_q.ext_mode;
    assign out_rtype    = bundle_q.rtype;
    assign out_pc4      = bundle_q.pc4;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a reference model.
module tb_id_stage;

    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc4;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_opcode;
    logic [4:0]    out_rs;
    logic [4:0]    out_rt;
    logic [4:0]    out_rd;
    logic [4:0]    out_shamt;
    logic [5:0]    out_funct;
    logic [31:0]   out_imm;
    logic [1:0]    out_ext_mode;
    logic          out_rtype;
    logic [31:0]   out_pc4;
    logic [SW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    id_stage #(.DATA_W(32), .STALL_CNT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc4       (in_pc4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_shamt    (out_shamt),
        .out_funct    (out_funct),
        .out_imm      (out_imm),
        .out_ext_mode (out_ext_mode),
        .out_rtype    (out_rtype),
        .out_pc4      (out_pc4),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned exp_mode(input logic [31:0] ins);
        int unsigned op = ins >> 26;
        if (op == 12 || op == 13 || op == 14) return 1;
        if (op == 15) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] ins);
        int unsigned imm = ins & 32'hFFFF;
        case (exp_mode(ins))
            1:       return imm;
            2:       return imm * 65536;
            default: return (imm >= 32768) ? imm + 32'hFFFF0000 : imm;
        endcase
    endfunction

    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    int          m_stall;
    logic        m_took;
    logic        m_ready;

    assign m_ready = !m_valid || out_ready;

    // Model state advances on the same edges as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_instr <= '0;
            m_pc4   <= '0;
            m_stall <= 0;
            m_took  <= 1'b0;
        end else begin
            if (m_valid && !out_ready && m_stall < (1 << SW) - 1) m_stall <= m_stall + 1;
            m_took <= in_valid && (m_ready || flush);
            if (flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && m_ready) begin
                m_valid <= 1'b1;
                m_instr <= in_instr;
                m_pc4   <= in_pc4;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
            check("stall_cnt", {28'b0, stall_cnt}, m_stall);
            if (m_valid) begin
                check("opcode", {26'b0, out_opcode}, m_instr >> 26);
                check("rs",     {27'b0, out_rs},    (m_instr >> 21) & 31);
                check("rt",     {27'b0, out_rt},    (m_instr >> 16) & 31);
                check("rd",     {27'b0, out_rd},    (m_instr >> 11) & 31);
                check("shamt",  {27'b0, out_shamt}, (m_instr >> 6) & 31);
                check("funct",  {26'b0, out_funct}, m_instr & 63);
                check("imm",    out_imm, exp_imm(m_instr));
                check("ext_mode", {30'b0, out_ext_mode}, exp_mode(m_instr));
                check("rtype",  {31'b0, out_rtype}, {31'b0, (m_instr >> 26) == 0});
                check("pc4",    out_pc4, m_pc4);
            end
        end
    end

    // Advance one clock; return just after the falling edge so inputs change mid-cycle
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    logic [31:0] seq_instr [4];
    logic [5:0]  seq_op    [4];
    logic [5:0]  op_tab    [12];

    initial begin
        seq_instr[0] = 32'h8D090004; seq_op[0] = 6'h23;
        seq_instr[1] = 32'hAD090008; seq_op[1] = 6'h2B;
        seq_instr[2] = 32'h1109FFFF; seq_op[2] = 6'h04;
        seq_instr[3] = 32'h01095020; seq_op[3] = 6'h00;
        op_tab[0] = 6'h00; op_tab[1] = 6'h04; op_tab[2]  = 6'h05; op_tab[3]  = 6'h08;
        op_tab[4] = 6'h09; op_tab[5] = 6'h0A; op_tab[6]  = 6'h0C; op_tab[7]  = 6'h0D;
        op_tab[8] = 6'h0E; op_tab[9] = 6'h0F; op_tab[10] = 6'h23; op_tab[11] = 6'h2B;

        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_instr = '0; in_pc4 = '0;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_imm",       out_imm, 32'd0);
        check("rst_pc4",       out_pc4, 32'd0);
        check("rst_stall",     {28'b0, stall_cnt}, 32'd0);
        rst_n = 1;
        chk_en = 1;
        tick();

        // ADDI, ORI, LUI
        out_ready = 1; in_valid = 1; in_instr = 32'h2128FFFA; in_pc4 = 32'h4;
        tick();
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_rs",    {27'b0, out_rs}, 32'd9);
        check("addi_rt",    {27'b0, out_rt}, 32'd8);
        check("addi_imm",   out_imm, 32'hFFFFFFFA);
        check("addi_mode",  {30'b0, out_ext_mode}, 32'd0);
        in_instr = 32'h35288000; in_pc4 = 32'h8;
        tick();
        check("ori_imm",  out_imm, 32'h00008000);
        check("ori_mode", {30'b0, out_ext_mode}, 32'd1);
        in_instr = 32'h3C081234; in_pc4 = 32'hC;
        tick();
        check("lui_imm",  out_imm, 32'h12340000);
        check("lui_mode", {30'b0, out_ext_mode}, 32'd2);

        // Back-to-back four
        for (int i = 0; i < 4; i++) begin
            in_instr = seq_instr[i]; in_pc4 = 32'h10 + 4 * i;
            tick();
            check("b2b_valid", {31'b0, out_valid}, 32'd1);
            check("b2b_opcode", {26'b0, out_opcode}, {26'b0, seq_op[i]});
        end
        in_valid = 0;
        tick();
        check("b2b_drained", {31'b0, out_valid}, 32'd0);
        check("b2b_stall",   {28'b0, stall_cnt}, 32'd0);

        // Hold for five cycles
        in_valid = 1; in_instr = 32'h2128FFFA; in_pc4 = 32'h40; out_ready = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_imm",   out_imm, 32'hFFFFFFFA);
            check("hold_pc4",   out_pc4, 32'h40);
            check("hold_ready", {31'b0, in_ready}, 32'd0);
        end
        check("hold_stall", {28'b0, stall_cnt}, 32'd5);
        out_ready = 1;
        tick();
        check("release_valid", {31'b0, out_valid}, 32'd0);
        check("release_ready", {31'b0, in_ready}, 32'd1);

        // Flush with incoming instruction while stalled
        in_valid = 1; in_instr = 32'h35288000; in_pc4 = 32'h50; out_ready = 0;
        tick();
        in_instr = 32'h3C081234; in_pc4 = 32'h54; flush = 1;
        tick();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 0; in_valid = 0;
        tick();
        check("flush_not_captured", {31'b0, out_valid}, 32'd0);

        // Saturation then asynchronous reset mid-stall
        in_valid = 1; in_instr = 32'h8D090004; in_pc4 = 32'h60;
        tick();
        in_valid = 0;
        repeat (20) tick();
        check("sat_stall", {28'b0, stall_cnt}, 32'd15);
        tick();
        check("sat_hold", {28'b0, stall_cnt}, 32'd15);
        check("sat_valid", {31'b0, out_valid}, 32'd1);
        chk_en = 0;
        rst_n = 0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_stall", {28'b0, stall_cnt}, 32'd0);
        tick();
        rst_n = 1;
        chk_en = 1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || m_took) begin
                in_instr = $urandom;
                if ($urandom_range(1, 0) == 1)
                    in_instr[31:26] = op_tab[$urandom_range(11, 0)];
                in_pc4 = $urandom;
                in_valid = ($urandom_range(9, 0) < 7);
            end
            out_ready = ($urandom_range(9, 0) < 6);
            flush = ($urandom_range(15, 0) == 0);
            tick();
        end
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
